peripheral_arbiter_wb: RTL and testbench



---
 rtl/peripheral_arbiter_wb_pkg.sv | 21 ++
 rtl/peripheral_arbiter_rr_wb.sv | 36 +++
 rtl/peripheral_arbiter_wb.sv | 175 +++++++++++++++++
 tb/tb_peripheral_arbiter_wb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_arbiter_wb_pkg.sv
// Shared types and Wibshbone burst-tag constants for the round-robin bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package peripheral_arbiter_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/peripheral_arbiter_rr_wb.sv
// Combinational round-robin picker: first set request found circularly after ptr.
// The request vector is doubled so the circular search becomes a plain shift plus priority encode.
module peripheral_arbiter_rr_wb
    import peripheral_arbiter_wb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  start;

    always_comb begin
        start = (ptr == IW'(N - 1)) ? '0 : IW'(ptr + 1'b1);
        dbl   = {req, req};
        rot   = N'(dbl >> start);
        idx   = '0;
        valid = 1'b0;
        // Walk downwards so the lowest rotated position (nearest to start) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                idx   = IW'((int'(start) + i) % N);
            end
        end
        gnt = valid ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// Wishbone B3 round-robin arbiter: N masters share one slave, grant held for the whole cyc.
// A watchdog aborts cycles whose strobe stalls for TIMEOUT cycles by returning err to the owner.
//
// state | meaning
// IDLE  | no owner; all slave-side and termination outputs 0; arbitrate on any cyc
// BUSY  | owner's request muxed to slave, slave terminations routed back to owner
// ABORT | one cycle: slave cyc/stb dropped, err pulsed to owner
module peripheral_arbiter_wb
    import peripheral_arbiter_wb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [DW-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d, ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] owner_oh_q, owner_oh_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   own_cyc, own_stb, slv_term, stall, wdog_hit;

    peripheral_arbiter_rr_wb #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr (
        .req   (wbm_cyc_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign own_cyc   = wbm_cyc_i[owner_q];
    assign own_stb   = wbm_stb_i[owner_q];
    assign slv_term  = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign stall     = (state_q == BUSY) && own_cyc && own_stb && !slv_term;
    assign wbm_dat_o = wbs_dat_i;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        ptr_d      = ptr_q;
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbs_sel_o  = '0;
        wbs_we_o   = 1'b0;
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_cti_o  = '0;
        wbs_bte_o  = '0;
        wbm_ack_o  = '0;
        wbm_err_o  = '0;
        wbm_rty_o  = '0;
        grant_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d    = pick_idx;
                    owner_oh_d = pick_gnt;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                grant_o            = owner_oh_q;
                wbs_adr_o          = wbm_adr_i[int'(owner_q)*AW +: AW];
                wbs_dat_o          = wbm_dat_i[int'(owner_q)*DW +: DW];
                wbs_sel_o          = wbm_sel_i[int'(owner_q)*SW +: SW];
                wbs_cti_o          = wbm_cti_i[int'(owner_q)*3 +: 3];
                wbs_bte_o          = wbm_bte_i[int'(owner_q)*2 +: 2];
                wbs_we_o           = wbm_we_i[owner_q];
                wbs_cyc_o          = own_cyc;
                wbs_stb_o          = own_stb;
                // Terminations pass through even as cyc drops so a final ack is not lost.
                wbm_ack_o[owner_q] = wbs_ack_i;
                wbm_err_o[owner_q] = wbs_err_i;
                wbm_rty_o[owner_q] = wbs_rty_i;
                if (!own_cyc) begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else if (wdog_hit) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                grant_o            = owner_oh_q;
                wbm_err_o[owner_q] = 1'b1;
                if (own_cyc) begin
                    state_d = BUSY;
                end else begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            owner_oh_q <= '0;
            ptr_q      <= IW'(NUM_MASTERS - 1);
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            ptr_q      <= ptr_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] wdog_q, wdog_d;

            // Abort on the edge that ends the TIMEOUT-th stalled cycle; a termination that
            // same cycle means no stall, so the ack wins.
            assign wdog_hit = stall && (wdog_q == CW'(TIMEOUT - 1));

            always_comb begin
                wdog_d = wdog_q;
                if ((state_d != state_q) || slv_term) begin
                    wdog_d = '0;
                end else if (stall && (wdog_q != CW'(TIMEOUT))) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) wdog_q <= '0;
                else            wdog_q <= wdog_d;
            end
        end else begin : g_no_wdog
            assign wdog_hit = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Directed bench for the round-robin arbiter with a small zero-wait memory slave.
// Each step drives inputs just after the rising edge and checks 1-2 time units later.
module tb_peripheral_arbiter_wb;
    import peripheral_arbiter_wb_pkg::*;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*4-1:0]   m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb;
    logic [NM*3-1:0]   m_cti;
    logic [NM*2-1:0]   m_bte;
    logic [DW-1:0]     wbm_dat_o;
    logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o, s_dat;
    logic [3:0]        wbs_sel_o;
    logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]        wbs_cti_o;
    logic [1:0]        wbs_bte_o;
    logic              s_ack, s_err, s_rty, ack_en;
    logic [31:0]       mem [0:255];
    logic [2:0]        bcti [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign s_ack = wbs_cyc_o & wbs_stb_o & ack_en;
    assign s_dat = mem[wbs_adr_o[9:2]];
    assign s_err = 1'b0;
    assign s_rty = 1'b0;

    always @(posedge clk) begin
        if (s_ack && wbs_we_o) mem[wbs_adr_o[9:2]] <= wbs_dat_o;
    end

    peripheral_arbiter_wb #(
        .NUM_MASTERS (NM),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbm_adr_i (m_adr),
        .wbm_dat_i (m_dat),
        .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),
        .wbm_cyc_i (m_cyc),
        .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),
        .wbm_bte_i (m_bte),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (s_dat),
        .wbs_ack_i (s_ack),
        .wbs_err_i (s_err),
        .wbs_rty_i (s_rty),
        .grant_o   (grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        m_cyc[k]          = cyc;
        m_stb[k]          = cyc;
        m_we[k]           = we;
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_sel[k*4 +: 4]   = {4{cyc}};
        m_cti[k*3 +: 3]   = cti;
        m_bte[k*2 +: 2]   = BTE_LINEAR;
    endtask

    task automatic clr(input int k);
        set_m(k, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    endtask

    task automatic do_reset;
        for (int k = 0; k < NM; k++) clr(k);
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=still_running expected=finished");
        $fatal(1);
    end

    initial begin
        bcti[0] = CTI_INCR;
        bcti[1] = CTI_INCR;
        bcti[2] = CTI_INCR;
        bcti[3] = CTI_EOB;
        ack_en  = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int k = 0; k < NM; k++) clr(k);

        #2;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_cyc", 32'(wbs_cyc_o), 32'h0);
        chk("rst_ack", 32'(wbm_ack_o), 32'h0);
        step;
        step;
        rst_n = 1'b1;

        // single write then read-back by master 0
        set_m(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, CTI_CLASSIC);
        #1 chk("wr_req_cycle_cyc", 32'(wbs_cyc_o), 32'h0);
        step;
        #1;
        chk("wr_cyc", 32'(wbs_cyc_o), 32'h1);
        chk("wr_adr", wbs_adr_o, 32'h10);
        chk("wr_dat", wbs_dat_o, 32'hDEADBEEF);
        chk("wr_we", 32'(wbs_we_o), 32'h1);
        chk("wr_grant", 32'(grant_o), 32'h1);
        chk("wr_ack", 32'(wbm_ack_o), 32'h1);
        step;
        clr(0);
        #1 chk("wr_release_cyc", 32'(wbs_cyc_o), 32'h0);
        step;
        set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        step;
        #1;
        chk("rd_dat", wbm_dat_o, 32'hDEADBEEF);
        chk("rd_ack", 32'(wbm_ack_o), 32'h1);
        step;
        clr(0);
        step;

        // masters 0 and 2 request together
        do_reset;
        set_m(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        set_m(2, 1'b1, 1'b0, 32'h4, 32'h0, CTI_CLASSIC);
        step;
        #1 chk("pair_first_grant", 32'(grant_o), 32'h1);
        step;
        clr(0);
        #1;
        chk("pair_release_grant", 32'(grant_o), 32'h1);
        chk("pair_release_cyc", 32'(wbs_cyc_o), 32'h0);
        step;
        #1 chk("pair_idle_grant", 32'(grant_o), 32'h0);
        step;
        #1;
        chk("pair_second_grant", 32'(grant_o), 32'h4);
        chk("pair_second_ack", 32'(wbm_ack_o), 32'h4);
        step;
        clr(2);
        step;

        // all four masters keep issuing single reads
        do_reset;
        for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b0, 32'(k * 4), 32'h0, CTI_CLASSIC);
        for (int n = 0; n < 6; n++) begin
            step;
            #1;
            chk($sformatf("rr_grant_%0d", n), 32'(grant_o), 32'h1 << (n % NM));
            chk($sformatf("rr_ack_%0d", n), 32'(wbm_ack_o), 32'h1 << (n % NM));
            step;
            m_cyc[n % NM] = 1'b0;
            m_stb[n % NM] = 1'b0;
            step;
            m_cyc[n % NM] = 1'b1;
            m_stb[n % NM] = 1'b1;
        end
        for (int k = 0; k < NM; k++) clr(k);
        step;

        // master 1 INCR burst while master 3 waits
        do_reset;
        set_m(1, 1'b1, 1'b0, 32'h40, 32'h0, bcti[0]);
        m_bte[1*2 +: 2] = BTE_WRAP4;
        set_m(3, 1'b1, 1'b0, 32'h80, 32'h0, CTI_CLASSIC);
        step;
        #1;
        chk("burst_grant_0", 32'(grant_o), 32'h2);
        chk("burst_cti_0", 32'(wbs_cti_o), 32'(CTI_INCR));
        chk("burst_bte", 32'(wbs_bte_o), 32'(BTE_WRAP4));
        chk("burst_ack_0", 32'(wbm_ack_o), 32'h2);
        for (int b = 1; b < 4; b++) begin
            step;
            m_cti[1*3 +: 3] = bcti[b];
            #1;
            chk($sformatf("burst_grant_%0d", b), 32'(grant_o), 32'h2);
            chk($sformatf("burst_cti_%0d", b), 32'(wbs_cti_o), 32'(bcti[b]));
            chk($sformatf("burst_ack_%0d", b), 32'(wbm_ack_o), 32'h2);
        end
        step;
        clr(1);
        #1;
        chk("burst_release_grant", 32'(grant_o), 32'h2);
        chk("burst_release_cyc", 32'(wbs_cyc_o), 32'h0);
        step;
        #1 chk("burst_idle_grant", 32'(grant_o), 32'h0);
        step;
        #1;
        chk("burst_m3_grant", 32'(grant_o), 32'h8);
        chk("burst_m3_ack", 32'(wbm_ack_o), 32'h8);
        step;
        clr(3);
        step;

        // watchdog: ack on the threshold cycle wins, then a full stall aborts
        do_reset;
        ack_en = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h20, 32'h0, CTI_CLASSIC);
        set_m(1, 1'b1, 1'b0, 32'h24, 32'h0, CTI_CLASSIC);
        for (int i = 1; i <= TO - 1; i++) begin
            step;
            #1;
            chk($sformatf("wd_pre_err_%0d", i), 32'(wbm_err_o), 32'h0);
            chk($sformatf("wd_pre_cyc_%0d", i), 32'(wbs_cyc_o), 32'h1);
        end
        step;
        ack_en = 1'b1;
        #1;
        chk("wd_thresh_ack", 32'(wbm_ack_o), 32'h1);
        chk("wd_thresh_err", 32'(wbm_err_o), 32'h0);
        step;
        ack_en = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            #1;
            chk($sformatf("wd_stall_err_%0d", i), 32'(wbm_err_o), 32'h0);
            chk($sformatf("wd_stall_cyc_%0d", i), 32'(wbs_cyc_o), 32'h1);
            step;
        end
        clr(0);
        #1;
        chk("wd_abort_err", 32'(wbm_err_o), 32'h1);
        chk("wd_abort_cyc", 32'(wbs_cyc_o), 32'h0);
        chk("wd_abort_stb", 32'(wbs_stb_o), 32'h0);
        chk("wd_abort_grant", 32'(grant_o), 32'h1);
        step;
        #1 chk("wd_idle_grant", 32'(grant_o), 32'h0);
        step;
        ack_en = 1'b1;
        #1;
        chk("wd_next_grant", 32'(grant_o), 32'h2);
        chk("wd_next_ack", 32'(wbm_ack_o), 32'h2);
        chk("wd_next_err", 32'(wbm_err_o), 32'h0);
        step;
        clr(1);
        step;

        // reset pulse in the middle of a master 2 burst
        set_m(2, 1'b1, 1'b0, 32'h60, 32'h0, CTI_INCR);
        step;
        #1 chk("mid_grant", 32'(grant_o), 32'h4);
        step;
        #1 chk("mid_ack", 32'(wbm_ack_o), 32'h4);
        set_m(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant_o), 32'h0);
        chk("mid_rst_cyc", 32'(wbs_cyc_o), 32'h0);
        chk("mid_rst_stb", 32'(wbs_stb_o), 32'h0);
        chk("mid_rst_adr", wbs_adr_o, 32'h0);
        chk("mid_rst_ack", 32'(wbm_ack_o), 32'h0);
        step;
        step;
        #1 chk("mid_rst_held_grant", 32'(grant_o), 32'h0);
        rst_n = 1'b1;
        step;
        #1;
        chk("post_rst_grant", 32'(grant_o), 32'h1);
        chk("post_rst_adr", wbs_adr_o, 32'h0);
        clr(0);
        clr(2);
        step;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
